// File: rtl/axis_overlap_pkg.sv
// Shared helpers for the overlap-add family: tail sizing, config clamping,
// and signed saturating addition.
package axis_overlap_pkg;

  typedef enum logic {
    BEAT_HEAD,
    BEAT_TAIL
  } beat_e;

  function automatic int tail_depth(input int max_depth);
    return 1 << (max_depth - 1);
  endfunction

  function automatic int clamp_depth(input int depth, input int max_depth);
    if (depth < 1) return 1;
    if (depth > max_depth) return max_depth;
    return depth;
  endfunction

  // Overlap may never exceed half a frame, so tail reads and writes stay disjoint.
  function automatic int clamp_overlap(input int overlap, input int depth);
    int half;
    half = 1 << (depth - 1);
    return (overlap > half) ? half : overlap;
  endfunction

  function automatic int sat_add(input int a, input int b, input int width);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (width - 1)) - 1;
    lo  = -(1 << (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/axis_overlap_tail_ram.sv
// Simple dual-port tail store: synchronous read, write-first bypass when the
// read and write addresses collide in the same cycle.
module axis_overlap_tail_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; validity is tracked outside.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_overlap_add.sv
// Overlap-add reassembler: sums each frame's head with the stored tail of the
// previous frame and emits hop = N - O saturated samples per frame.
module axis_overlap_add
  import axis_overlap_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_N_DEPTH      = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [3:0]                  cfg_depth,
  input  logic [MAX_N_DEPTH-2:0]      cfg_overlap,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int KW = MAX_N_DEPTH;
  localparam int HW = MAX_N_DEPTH + 1;
  localparam int AW = MAX_N_DEPTH - 1;
  localparam int TAIL_DEPTH = tail_depth(MAX_N_DEPTH);

  logic [KW-1:0] k, k_next, n_last, lat_n_last, ovl, lat_ovl, ovl_c;
  logic [HW-1:0] hop, lat_hop, wr_off;
  logic [3:0]    depth_c, lat_depth;
  logic          tail_valid, eff_tail_valid, first_beat, accept, wr_en;
  beat_e         beat;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic signed [DATA_WIDTH-1:0] sum_sat;
  int                           addend;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    depth_c    = 4'(clamp_depth(int'(cfg_depth), MAX_N_DEPTH));
    ovl_c      = KW'(clamp_overlap(int'(cfg_overlap), int'(depth_c)));
    first_beat = (k == '0);
    // Beat 0 runs on the live config, which is what gets latched for the frame.
    if (first_beat) begin
      n_last         = KW'((1 << int'(depth_c)) - 1);
      ovl            = ovl_c;
      hop            = HW'((1 << int'(depth_c)) - int'(ovl_c));
      eff_tail_valid = tail_valid && (depth_c == lat_depth) && (ovl_c == lat_ovl);
    end else begin
      n_last         = lat_n_last;
      ovl            = lat_ovl;
      hop            = lat_hop;
      eff_tail_valid = tail_valid;
    end
    beat          = ({1'b0, k} >= hop) ? BEAT_TAIL : BEAT_HEAD;
    s_axis_tready = !areset && ((beat == BEAT_TAIL) || !m_axis_tvalid || m_axis_tready);
    accept        = s_axis_tvalid && s_axis_tready;
    if (!accept)           k_next = k;
    else if (k == n_last)  k_next = '0;
    else                   k_next = k + KW'(1);
    addend  = ((k < ovl) && eff_tail_valid) ? int'(signed'(rd_data)) : 0;
    sum_sat = DATA_WIDTH'(sat_add(int'(signed'(s_axis_tdata[DATA_WIDTH-1:0])), addend, DATA_WIDTH));
    wr_en   = accept && (beat == BEAT_TAIL);
    wr_off  = {1'b0, k} - hop;
  end

  // Read address runs one beat ahead so tail[k] is waiting when beat k arrives.
  axis_overlap_tail_ram #(
    .DEPTH (TAIL_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_tail_ram (
    .clk     (aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_off[AW-1:0]),
    .wr_data (s_axis_tdata[DATA_WIDTH-1:0]),
    .rd_addr (k_next[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      k             <= '0;
      tail_valid    <= 1'b0;
      lat_depth     <= '0;
      lat_ovl       <= '0;
      lat_n_last    <= '0;
      lat_hop       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (accept) begin
        k <= k_next;
        if (first_beat) begin
          lat_depth  <= depth_c;
          lat_ovl    <= ovl_c;
          lat_n_last <= n_last;
          lat_hop    <= hop;
          tail_valid <= eff_tail_valid;
        end
        if (k == n_last) tail_valid <= 1'b1;
      end
      if (accept && (beat == BEAT_HEAD)) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= AXIS_TDATA_WIDTH'(sum_sat);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, s_axis_tdata, k_next, wr_off};

endmodule
